hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the BEAN-2 pipeline, a successor to the fixed five-stage `hazard_logic`. It tracks pending register writes in a shift-register scoreboard spanning `STAGES` post-decode stages, and from that scoreboard produces per-source forwarding selects, load-use stalls, jump flushes and memory-wait freezes. It sits beside `control_logic` and drives the stall/flush inputs of `datapath` (F, D, then E..WB).

---
 rtl/bean_pkg.sv | 27 ++
 rtl/hazard_src_match.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bean_pkg.sv
// Shared definitions for the BEAN-2 hazard unit: register address width, stage
// indices, scoreboard field widths and result-ready encodings.
package bean_pkg;

    localparam int REG_AW    = 5;

    localparam int STG_E     = 0;
    localparam int STG_M     = 1;
    localparam int STG_WB    = 2;

    localparam int SB_VLD_W  = 1;
    localparam int SB_WE_W   = 1;
    localparam int SB_RD_W   = REG_AW;

    localparam int RDY_ALU   = 0;
    localparam int RDY_LOAD  = 1;

    // A one-stage pipeline still needs a 1-bit ready field.
    function automatic int rdy_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    function automatic int fwd_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source operand against every scoreboard entry and reports the
// youngest matching writer and whether its result is not yet available.
module hazard_src_match
    import bean_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int AW     = REG_AW,
    parameter int RW     = rdy_width(STAGES),
    parameter int FW     = fwd_width(STAGES)
) (
    input  logic [AW-1:0]        rs,
    input  logic                 used,
    input  logic [STAGES-1:0]    ent_valid,
    input  logic [STAGES-1:0]    ent_we,
    input  logic [STAGES*AW-1:0] ent_rd,
    input  logic [STAGES*RW-1:0] ent_rdy,
    output logic                 match,
    output logic [FW-1:0]        idx,
    output logic                 hazard
);

    logic [RW-1:0] sel_rdy;

    always_comb begin
        match   = 1'b0;
        idx     = '0;
        hazard  = 1'b0;
        sel_rdy = '0;
        if (used && (rs != '0)) begin
            // Walk oldest to youngest so the youngest writer is the one kept.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (ent_valid[k] && ent_we[k] && (ent_rd[k*AW +: AW] == rs)) begin
                    match   = 1'b1;
                    idx     = FW'(k);
                    sel_rdy = ent_rdy[k*RW +: RW];
                end
            end
            if (match && (int'(idx) < int'(sel_rdy))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// BEAN-2 hazard unit: shift-register scoreboard of pending writes driving
// forwarding selects, load-use stalls, jump flushes and memory-wait freezes.
module hazard_scoreboard
    import bean_pkg::*;
#(
    parameter int  STAGES  = 3,
    parameter int  NUM_SRC = 3,
    parameter int  REG_AW  = bean_pkg::REG_AW,
    parameter int  PERF_W  = 16,
    localparam int RW      = rdy_width(STAGES),
    localparam int FW      = fwd_width(STAGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic                      issue_we,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [RW-1:0]             issue_rdy,
    input  logic [NUM_SRC*REG_AW-1:0] rs_addr,
    input  logic [NUM_SRC-1:0]        rs_used,
    input  logic                      jump,
    input  logic                      mem_wait,
    output logic                      stall_F,
    output logic                      stall_D,
    output logic                      flush_F,
    output logic                      flush_D,
    output logic [STAGES-1:0]         stall,
    output logic [STAGES-1:0]         flush,
    output logic [NUM_SRC*FW-1:0]     fwd_sel,
    output logic [PERF_W-1:0]         stall_cnt,
    output logic [PERF_W-1:0]         flush_cnt
);

    logic [STAGES-1:0]             sb_valid_q, sb_valid_d;
    logic [STAGES-1:0]             sb_we_q,    sb_we_d;
    logic [STAGES-1:0][REG_AW-1:0] sb_rd_q,    sb_rd_d;
    logic [STAGES-1:0][RW-1:0]     sb_rdy_q,   sb_rdy_d;
    logic [PERF_W-1:0]             stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0]             flush_cnt_q, flush_cnt_d;

    logic [NUM_SRC-1:0]            src_match;
    logic [NUM_SRC-1:0]            src_hazard;
    logic [NUM_SRC-1:0][FW-1:0]    src_idx;
    logic                          hazard_any;
    logic                          bubble_e0;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .STAGES (STAGES),
            .AW     (REG_AW),
            .RW     (RW),
            .FW     (FW)
        ) u_match (
            .rs        (rs_addr[i*REG_AW +: REG_AW]),
            .used      (rs_used[i]),
            .ent_valid (sb_valid_q),
            .ent_we    (sb_we_q),
            .ent_rd    (sb_rd_q),
            .ent_rdy   (sb_rdy_q),
            .match     (src_match[i]),
            .idx       (src_idx[i]),
            .hazard    (src_hazard[i])
        );

        // Select k+1 means "forward from stage k"; 0 falls back to the regfile.
        assign fwd_sel[i*FW +: FW] = (reset && src_match[i] && !src_hazard[i])
                                     ? src_idx[i] + FW'(1) : '0;
    end

    assign hazard_any = issue_valid && (|src_hazard);

    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        flush_F     = 1'b0;
        flush_D     = 1'b0;
        stall       = '0;
        flush       = '0;
        bubble_e0   = 1'b0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset) begin
            flush_F = 1'b1;
            flush_D = 1'b1;
            flush   = '1;
        end else if (mem_wait) begin
            // A pending jump waits here; it is taken once memory is ready.
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall   = '1;
        end else if (jump) begin
            // The would-be dependent is flushed, so any data hazard is moot.
            flush_F        = 1'b1;
            flush_D        = 1'b1;
            flush[STG_E]   = 1'b1;
            bubble_e0      = 1'b1;
            flush_cnt_d    = sat_inc(flush_cnt_q);
        end else if (hazard_any) begin
            stall_F        = 1'b1;
            stall_D        = 1'b1;
            flush[STG_E]   = 1'b1;
            bubble_e0      = 1'b1;
            stall_cnt_d    = sat_inc(stall_cnt_q);
        end
    end

    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_we_d    = sb_we_q;
        sb_rd_d    = sb_rd_q;
        sb_rdy_d   = sb_rdy_q;
        if (!mem_wait) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                sb_valid_d[k] = sb_valid_q[k-1];
                sb_we_d[k]    = sb_we_q[k-1];
                sb_rd_d[k]    = sb_rd_q[k-1];
                sb_rdy_d[k]   = sb_rdy_q[k-1];
            end
            if (bubble_e0) begin
                sb_valid_d[0] = 1'b0;
                sb_we_d[0]    = 1'b0;
                sb_rd_d[0]    = '0;
                sb_rdy_d[0]   = '0;
            end else begin
                sb_valid_d[0] = issue_valid;
                sb_we_d[0]    = issue_we;
                sb_rd_d[0]    = issue_rd;
                sb_rdy_d[0]   = issue_rdy;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_valid_q  <= '0;
            sb_we_q     <= '0;
            sb_rd_q     <= '0;
            sb_rdy_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_valid_q  <= sb_valid_d;
            sb_we_q     <= sb_we_d;
            sb_rd_q     <= sb_rd_d;
            sb_rdy_q    <= sb_rdy_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counters read zero for as long as reset is held.
    assign stall_cnt = reset ? stall_cnt_q : '0;
    assign flush_cnt = reset ? flush_cnt_q : '0;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with STAGES=3: a cycle-by-cycle vector
// table followed by mem_wait/jump and reset-during-stall sequences.
module tb_hazard_scoreboard;

    localparam int STAGES  = 3;
    localparam int NUM_SRC = 3;
    localparam int REG_AW  = 5;
    localparam int PERF_W  = 16;

    logic                      clk;
    logic                      reset;
    logic                      issue_valid;
    logic                      issue_we;
    logic [REG_AW-1:0]         issue_rd;
    logic [1:0]                issue_rdy;
    logic [NUM_SRC*REG_AW-1:0] rs_addr;
    logic [NUM_SRC-1:0]        rs_used;
    logic                      jump;
    logic                      mem_wait;
    logic                      stall_F, stall_D, flush_F, flush_D;
    logic [STAGES-1:0]         stall, flush;
    logic [5:0]                fwd_sel;
    logic [PERF_W-1:0]         stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(
        .STAGES  (STAGES),
        .NUM_SRC (NUM_SRC),
        .REG_AW  (REG_AW),
        .PERF_W  (PERF_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_rdy   (issue_rdy),
        .rs_addr     (rs_addr),
        .rs_used     (rs_used),
        .jump        (jump),
        .mem_wait    (mem_wait),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_F     (flush_F),
        .flush_D     (flush_D),
        .stall       (stall),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        we;
        logic [4:0]  rd;
        logic [1:0]  rdy;
        logic [14:0] rs;
        logic [2:0]  used;
        logic        jmp;
        logic        mw;
        logic [3:0]  e_fd;     // {stall_F, stall_D, flush_F, flush_D}
        logic [2:0]  e_stall;
        logic [2:0]  e_flush;
        logic [5:0]  e_fwd;
        logic        chk_fwd;
        int          e_scnt;
        int          e_fcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic iv, input logic we, input int rd, input int rdy,
                                 input int a0, input int a1, input int a2, input logic [2:0] used,
                                 input logic jmp, input logic mw, input logic [3:0] fd,
                                 input logic [2:0] st, input logic [2:0] fl, input logic [5:0] fwd,
                                 input logic cf, input int sc, input int fc);
        vec_t v;
        v.iv = iv; v.we = we; v.rd = 5'(rd); v.rdy = 2'(rdy);
        v.rs = {5'(a2), 5'(a1), 5'(a0)};
        v.used = used; v.jmp = jmp; v.mw = mw;
        v.e_fd = fd; v.e_stall = st; v.e_flush = fl; v.e_fwd = fwd;
        v.chk_fwd = cf; v.e_scnt = sc; v.e_fcnt = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        issue_valid = v.iv;
        issue_we    = v.we;
        issue_rd    = v.rd;
        issue_rdy   = v.rdy;
        rs_addr     = v.rs;
        rs_used     = v.used;
        jump        = v.jmp;
        mem_wait    = v.mw;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " stall_F"},   32'(stall_F),   32'(v.e_fd[3]));
        chk({tag, " stall_D"},   32'(stall_D),   32'(v.e_fd[2]));
        chk({tag, " flush_F"},   32'(flush_F),   32'(v.e_fd[1]));
        chk({tag, " flush_D"},   32'(flush_D),   32'(v.e_fd[0]));
        chk({tag, " stall"},     32'(stall),     32'(v.e_stall));
        chk({tag, " flush"},     32'(flush),     32'(v.e_flush));
        if (v.chk_fwd) chk({tag, " fwd_sel"}, 32'(fwd_sel), 32'(v.e_fwd));
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(v.e_scnt));
        chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(v.e_fcnt));
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        apply(v);
        #1;
        check_vec(tag, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b0;
        apply(mkv(0,0,0,0, 0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'd0,0, 0,0));
        @(negedge clk);
        #1;
        check_vec("reset", mkv(0,0,0,0, 0,0,0,3'b000, 0,0, 4'b0011,3'b000,3'b111,6'd0,1, 0,0));
        @(negedge clk);
        reset = 1'b1;

        //             iv we rd rdy  a0 a1 a2 used  j mw  fd      stall  flush  fwd        cf sc fc
        vecs.push_back(mkv(1,1,5,0,  0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 0,0)); // add x5
        vecs.push_back(mkv(1,0,0,0,  5,0,0,3'b001, 0,0, 4'b0000,3'b000,3'b000,6'b000001,1, 0,0)); // use x5 from E
        vecs.push_back(mkv(1,1,6,1,  0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 0,0)); // lw x6
        vecs.push_back(mkv(1,0,0,0,  0,6,0,3'b010, 0,0, 4'b1100,3'b000,3'b001,6'b000000,0, 0,0)); // load-use stall
        vecs.push_back(mkv(1,0,0,0,  0,6,0,3'b010, 0,0, 4'b0000,3'b000,3'b000,6'b001000,1, 1,0)); // then fwd 2
        vecs.push_back(mkv(1,1,0,0,  6,0,5,3'b101, 0,0, 4'b0000,3'b000,3'b000,6'b000011,1, 1,0)); // x6 from WB, x5 retired
        vecs.push_back(mkv(1,1,7,0,  0,0,0,3'b001, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,0)); // rs1=x0 ignored
        vecs.push_back(mkv(1,1,8,0,  0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,0)); // add x8
        vecs.push_back(mkv(1,1,7,0,  7,0,0,3'b001, 0,0, 4'b0000,3'b000,3'b000,6'b000010,1, 1,0)); // x7 in M
        vecs.push_back(mkv(1,0,0,0,  7,8,0,3'b011, 0,0, 4'b0000,3'b000,3'b000,6'b001001,1, 1,0)); // youngest x7 wins
        vecs.push_back(mkv(1,1,9,1,  0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,0)); // lw x9
        vecs.push_back(mkv(1,0,0,0,  9,0,0,3'b001, 1,0, 4'b0011,3'b000,3'b001,6'b000000,0, 1,0)); // jump beats hazard
        vecs.push_back(mkv(0,0,0,0,  0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,1)); // counters after jump

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("v%0d", i), vecs[i]);
        end

        // mem_wait held 3 cycles with jump pending; x11 sits in M throughout.
        step("mw_setup0", mkv(1,1,11,0, 0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,1));
        step("mw_setup1", mkv(1,1,10,1, 0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,1));
        step("mw_c0", mkv(1,0,0,0, 11,0,0,3'b001, 1,1, 4'b1100,3'b111,3'b000,6'b000010,1, 1,1));
        step("mw_c1", mkv(1,0,0,0, 11,0,0,3'b001, 1,1, 4'b1100,3'b111,3'b000,6'b000010,1, 1,1));
        step("mw_c2", mkv(1,0,0,0, 11,0,10,3'b101, 1,1, 4'b1100,3'b111,3'b000,6'b000000,0, 1,1));
        step("mw_drop", mkv(1,0,0,0, 11,0,0,3'b001, 1,0, 4'b0011,3'b000,3'b001,6'b000010,1, 1,1));
        step("mw_after", mkv(0,0,0,0, 0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,2));

        // Reset asserted in the middle of a load-use stall.
        step("rst_lw", mkv(1,1,12,1, 0,0,0,3'b000, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 1,2));
        v = mkv(1,0,0,0, 12,0,0,3'b001, 0,0, 4'b1100,3'b000,3'b001,6'b000000,0, 1,2);
        step("rst_stall", v);
        #1;
        reset = 1'b0;
        #1;
        check_vec("rst_mid", mkv(1,0,0,0, 12,0,0,3'b001, 0,0, 4'b0011,3'b000,3'b111,6'b000000,1, 0,0));
        @(negedge clk);
        #1;
        check_vec("rst_hold", mkv(1,0,0,0, 12,0,0,3'b001, 0,0, 4'b0011,3'b000,3'b111,6'b000000,1, 0,0));
        reset = 1'b1;
        #1;
        check_vec("rst_rel", mkv(1,0,0,0, 12,0,0,3'b001, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 0,0));
        step("rst_next", mkv(1,0,0,0, 12,0,0,3'b001, 0,0, 4'b0000,3'b000,3'b000,6'b000000,1, 0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
